hazard_forward_unit: RTL and testbench

HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

---
 rtl/hazard_forward_unit_pkg.sv | 25 ++
 rtl/hazard_tag_pipe.sv | 32 +++
 rtl/hazard_forward_unit.sv | 150 +++++++++++++++
 tb/tb_hazard_forward_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_forward_unit_pkg.sv
// Shared types and helpers for the hazard / forwarding unit.
//   state_e    : hazard controller states
//   tag_ctl_t  : per-stage control flags of an in-flight instruction tag
//   sel_width  : width of a forwarding select able to encode 0..depth
package hazard_forward_unit_pkg;

  localparam int unsigned CNT_W = 3;  // holds LOAD_LAT-1 (<=2) and FLUSH_CYC (<=4)

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_LSTALL = 2'd1,
    ST_FLUSH  = 2'd2
  } state_e;

  typedef struct packed {
    logic valid;
    logic we;
    logic load;
  } tag_ctl_t;

  function automatic int unsigned sel_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hazard_tag_pipe.sv
// Shift register of destination tags following issued instructions down the pipe.
// Ports:
//   clk, rst_n : clock, async active-low reset (clears every entry to a bubble)
//   in_ctl     : control flags entering entry 1 (valid=0 inserts a bubble)
//   in_rd      : destination register entering entry 1
//   ctl, rd    : tag entries, index 0 = entry 1 (EX), index DEPTH-1 = oldest
module hazard_tag_pipe
  import hazard_forward_unit_pkg::*;
#(
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned REG_AW = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  tag_ctl_t                     in_ctl,
  input  logic [REG_AW-1:0]            in_rd,
  output tag_ctl_t [DEPTH-1:0]         ctl,
  output logic [DEPTH-1:0][REG_AW-1:0] rd
);

  // Every cycle each entry moves one stage older.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl <= '0;
      rd  <= '0;
    end else begin
      ctl <= {ctl[DEPTH-2:0], in_ctl};
      rd  <= {rd[DEPTH-2:0], in_rd};
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Data-hazard detection, load-use stall and branch flush control with
// per-source forwarding selects.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   issue_*     : instruction presented at decode (valid, sources, dest, we, load)
//   br_taken    : branch/jump resolved taken this cycle
//   stall       : combinational, hold PC and decode
//   flush       : registered, squash fetch/decode (asserts the cycle after br_taken)
//   fwd_sel     : combinational, per source: 0 = register file, k = stage k
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
#(
  parameter  int unsigned REG_AW    = 5,
  parameter  int unsigned DEPTH     = 3,
  parameter  int unsigned NSRC      = 2,
  parameter  int unsigned LOAD_LAT  = 1,
  parameter  int unsigned FLUSH_CYC = 2,
  localparam int unsigned SELW      = sel_width(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   issue_valid,
  input  logic [NSRC*REG_AW-1:0] issue_rs,
  input  logic [REG_AW-1:0]      issue_rd,
  input  logic                   issue_we,
  input  logic                   issue_load,
  input  logic                   br_taken,
  output logic                   stall,
  output logic                   flush,
  output logic [NSRC*SELW-1:0]   fwd_sel
);

  tag_ctl_t [DEPTH-1:0]         ctl;
  logic [DEPTH-1:0][REG_AW-1:0] rd;
  tag_ctl_t                     in_ctl;
  logic [NSRC-1:0][DEPTH-1:0]   hit;
  logic [NSRC-1:0]              ld_hit;
  logic                         hazard;
  state_e                       state, state_n;
  logic [CNT_W-1:0]             cnt, cnt_n;
  logic                         unused_load;

  hazard_tag_pipe #(
    .DEPTH  (DEPTH),
    .REG_AW (REG_AW)
  ) u_tag_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_ctl (in_ctl),
    .in_rd  (issue_rd),
    .ctl    (ctl),
    .rd     (rd)
  );

  // Per-source, per-stage producer match; x0 never matches.
  for (genvar i = 0; i < NSRC; i++) begin : g_src
    logic [REG_AW-1:0] rs;
    logic [SELW-1:0]   sel;

    assign rs = issue_rs[i*REG_AW +: REG_AW];

    for (genvar k = 0; k < DEPTH; k++) begin : g_stg
      assign hit[i][k] = ctl[k].valid && ctl[k].we && (rd[k] == rs) && (rd[k] != '0);
    end

    assign ld_hit[i] = hit[i][0] && ctl[0].load;

    // Youngest producer wins: scan oldest to youngest so the lowest stage overrides.
    always_comb begin
      sel = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (hit[i][k]) sel = SELW'(k + 1);
      end
    end

    assign fwd_sel[i*SELW +: SELW] = sel;
  end

  // Only entry 1's load flag matters for load-use detection.
  always_comb begin
    unused_load = 1'b0;
    for (int k = 1; k < DEPTH; k++) unused_load = unused_load ^ ctl[k].load;
  end

  assign hazard = issue_valid && !flush && (|ld_hit);

  // Entry 1 takes the issued instruction only when decode actually advances.
  always_comb begin
    in_ctl = '0;
    if (issue_valid && !stall && !flush) begin
      in_ctl.valid = 1'b1;
      in_ctl.we    = issue_we;
      in_ctl.load  = issue_load;
    end
  end

  // State register; flush is registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
      cnt   <= '0;
      flush <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      flush <= (state_n == ST_FLUSH);
    end
  end

  // Next state; a taken branch overrides everything and drops pending stalls.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      ST_RUN: begin
        if (hazard && (LOAD_LAT > 1)) begin
          state_n = ST_LSTALL;
          cnt_n   = CNT_W'(LOAD_LAT - 1);
        end
      end
      ST_LSTALL, ST_FLUSH: begin
        if (cnt <= CNT_W'(1)) begin
          state_n = ST_RUN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_n = ST_RUN;
        cnt_n   = '0;
      end
    endcase
    if (br_taken) begin
      state_n = ST_FLUSH;
      cnt_n   = CNT_W'(FLUSH_CYC);
    end
  end

  // Stall output, zero latency from the issue inputs.
  always_comb begin
    stall = 1'b0;
    case (state)
      ST_RUN:    stall = hazard;
      ST_LSTALL: stall = 1'b1;
      default:   stall = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_hazard_forward_unit;

  localparam int unsigned REG_AW    = 5;
  localparam int unsigned DEPTH     = 3;
  localparam int unsigned NSRC      = 2;
  localparam int unsigned LOAD_LAT  = 2;
  localparam int unsigned FLUSH_CYC = 2;
  localparam int unsigned SELW      = 2;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   issue_valid = 1'b0;
  logic [NSRC*REG_AW-1:0] issue_rs = '0;
  logic [REG_AW-1:0]      issue_rd = '0;
  logic                   issue_we = 1'b0;
  logic                   issue_load = 1'b0;
  logic                   br_taken = 1'b0;
  logic                   stall;
  logic                   flush;
  logic [NSRC*SELW-1:0]   fwd_sel;

  int errors = 0;
  int checks = 0;

  hazard_forward_unit #(
    .REG_AW    (REG_AW),
    .DEPTH     (DEPTH),
    .NSRC      (NSRC),
    .LOAD_LAT  (LOAD_LAT),
    .FLUSH_CYC (FLUSH_CYC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_rs    (issue_rs),
    .issue_rd    (issue_rd),
    .issue_we    (issue_we),
    .issue_load  (issue_load),
    .br_taken    (br_taken),
    .stall       (stall),
    .flush       (flush),
    .fwd_sel     (fwd_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: in-flight instructions as plain arrays, plus
  // remaining-flush and remaining-stall cycle counts.
  int m_v[DEPTH];
  int m_we[DEPTH];
  int m_ld[DEPTH];
  int m_rd[DEPTH];
  int flush_left = 0;
  int stall_left = 0;

  always @(negedge clk) begin : cmp
    int          rs;
    int          sel;
    bit          efl;
    bit          est;
    bit          haz;
    bit          accept;
    logic [31:0] efwd;
    efl  = 1'b0;
    est  = 1'b0;
    haz  = 1'b0;
    efwd = '0;
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        m_v[k] = 0; m_we[k] = 0; m_ld[k] = 0; m_rd[k] = 0;
      end
      flush_left = 0;
      stall_left = 0;
    end else begin
      efl = (flush_left > 0);
      for (int i = 0; i < NSRC; i++) begin
        rs  = int'(issue_rs[i*REG_AW +: REG_AW]);
        sel = 0;
        for (int k = 0; k < DEPTH; k++) begin
          if (sel == 0 && rs != 0 && m_v[k] != 0 && m_we[k] != 0 && m_rd[k] == rs) sel = k + 1;
        end
        efwd = efwd | (32'(sel) << (i * SELW));
        if (issue_valid && !efl && rs != 0 && m_v[0] != 0 && m_we[0] != 0 &&
            m_ld[0] != 0 && m_rd[0] == rs) haz = 1'b1;
      end
      est = !efl && (stall_left > 0 || haz);
    end
    check("model_stall", 32'(stall), 32'(est));
    check("model_flush", 32'(flush), 32'(efl));
    check("model_fwd_sel", 32'(fwd_sel), efwd);
    if (rst_n) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        m_v[k] = m_v[k-1]; m_we[k] = m_we[k-1]; m_ld[k] = m_ld[k-1]; m_rd[k] = m_rd[k-1];
      end
      accept  = issue_valid && !est && !efl;
      m_v[0]  = accept ? 1 : 0;
      m_we[0] = int'(issue_we);
      m_ld[0] = int'(issue_load);
      m_rd[0] = int'(issue_rd);
      if (br_taken) begin
        flush_left = FLUSH_CYC;
        stall_left = 0;
      end else if (flush_left > 0) begin
        flush_left--;
      end else if (stall_left > 0) begin
        stall_left--;
      end else if (haz) begin
        stall_left = LOAD_LAT - 1;
      end
    end
  end

  // Drive one cycle of inputs just after the rising edge, then let comb settle.
  task automatic step(input int v, input int rs0, input int rs1, input int rd,
                      input int we, input int ld, input int br);
    @(posedge clk);
    #1;
    issue_valid = 1'(v);
    issue_rs    = {REG_AW'(rs1), REG_AW'(rs0)};
    issue_rd    = REG_AW'(rd);
    issue_we    = 1'(we);
    issue_load  = 1'(ld);
    br_taken    = 1'(br);
    #1;
  endtask

  task automatic drain();
    repeat (3) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    check("reset_stall", 32'(stall), 0);
    check("reset_flush", 32'(flush), 0);
    check("reset_fwd", 32'(fwd_sel), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Forward from EX, then from MEM one cycle later.
    step(1, 0, 0, 5, 1, 0, 0);
    step(1, 5, 0, 6, 1, 0, 0);
    check("fwd_ex", 32'(fwd_sel), 32'h1);
    check("fwd_ex_nostall", 32'(stall), 0);
    step(1, 5, 0, 8, 1, 0, 0);
    check("fwd_mem", 32'(fwd_sel), 32'h2);
    drain();

    // Two producers of x5 in flight: youngest (stage 1) wins on source 1.
    step(1, 0, 0, 5, 1, 0, 0);
    step(1, 0, 0, 9, 1, 0, 0);
    step(1, 0, 0, 5, 1, 0, 0);
    step(1, 3, 5, 0, 0, 0, 0);
    check("fwd_youngest", 32'(fwd_sel), 32'h4);
    drain();
    step(1, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    check("fwd_x0", 32'(fwd_sel), 0);
    drain();

    // Load-use with LOAD_LAT=2: two stall cycles, load forwarded from stage 3 on issue.
    step(1, 0, 0, 7, 1, 1, 0);
    step(1, 7, 0, 10, 1, 0, 0);
    check("ldu_stall1", 32'(stall), 1);
    check("ldu_fwd1", 32'(fwd_sel), 32'h1);
    step(1, 7, 0, 10, 1, 0, 0);
    check("ldu_stall2", 32'(stall), 1);
    check("ldu_fwd2", 32'(fwd_sel), 32'h2);
    step(1, 7, 0, 10, 1, 0, 0);
    check("ldu_release", 32'(stall), 0);
    check("ldu_fwd3", 32'(fwd_sel), 32'h3);
    drain();

    // Load-use together with taken branch: flush wins, no extended stall.
    step(1, 0, 0, 7, 1, 1, 0);
    step(1, 7, 0, 11, 1, 0, 1);
    check("br_haz_stall", 32'(stall), 1);
    check("br_haz_flush0", 32'(flush), 0);
    step(1, 7, 0, 11, 1, 0, 0);
    check("br_flush1", 32'(flush), 1);
    check("br_flush1_nostall", 32'(stall), 0);
    step(1, 7, 0, 11, 1, 0, 0);
    check("br_flush2", 32'(flush), 1);
    check("br_flush2_nostall", 32'(stall), 0);
    step(1, 7, 0, 11, 1, 0, 0);
    check("br_flush_end", 32'(flush), 0);
    check("br_bubbles_fwd", 32'(fwd_sel), 0);
    check("br_bubbles_stall", 32'(stall), 0);
    drain();

    // Second branch while flush is first high: flush stays up three cycles.
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    check("reflush_c1", 32'(flush), 1);
    step(0, 0, 0, 0, 0, 0, 0);
    check("reflush_c2", 32'(flush), 1);
    step(0, 0, 0, 0, 0, 0, 0);
    check("reflush_c3", 32'(flush), 1);
    step(0, 0, 0, 0, 0, 0, 0);
    check("reflush_end", 32'(flush), 0);
    drain();

    // Reset in the middle of a load stall.
    step(1, 0, 0, 7, 1, 1, 0);
    step(1, 7, 0, 12, 0, 0, 0);
    check("rst_pre_stall1", 32'(stall), 1);
    step(1, 7, 0, 12, 0, 0, 0);
    check("rst_pre_stall2", 32'(stall), 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_stall", 32'(stall), 0);
    check("rst_mid_flush", 32'(flush), 0);
    check("rst_mid_fwd", 32'(fwd_sel), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("rst_after_fwd", 32'(fwd_sel), 0);
    step(1, 7, 0, 12, 0, 0, 0);
    check("rst_after_fwd2", 32'(fwd_sel), 0);
    check("rst_after_stall", 32'(stall), 0);
    step(1, 0, 0, 7, 1, 0, 0);
    step(1, 0, 7, 0, 0, 0, 0);
    check("rst_recover_fwd", 32'(fwd_sel), 32'h4);

    // Randomized traffic over a small register set to force frequent matches.
    for (int n = 0; n < 2000; n++) begin
      @(posedge clk);
      #1;
      rst_n       = ($urandom_range(0, 199) != 0);
      issue_valid = ($urandom_range(0, 3) != 0);
      issue_rs    = {REG_AW'($urandom_range(0, 7)), REG_AW'($urandom_range(0, 7))};
      issue_rd    = REG_AW'($urandom_range(0, 7));
      issue_we    = ($urandom_range(0, 4) != 0);
      issue_load  = ($urandom_range(0, 2) == 0);
      br_taken    = ($urandom_range(0, 7) == 0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
